// File: rtl/water_supply_arbiter_if.sv
// Handshake bundle between the washing-machine controllers and the shared
// inlet-valve arbiter.
interface water_supply_arbiter_if #(
    parameter int N_MACHINES = 4
) ();
    logic [N_MACHINES-1:0] req;
    logic                  pause;
    logic [N_MACHINES-1:0] grant;
    logic                  valve_open;
    logic [N_MACHINES-1:0] fill_done;
    logic                  busy;

    modport master (
        output req,
        output pause,
        input  grant,
        input  valve_open,
        input  fill_done,
        input  busy
    );

    modport slave (
        input  req,
        input  pause,
        output grant,
        output valve_open,
        output fill_done,
        output busy
    );
endinterface

// File: rtl/water_supply_arbiter.sv
// Round-robin arbiter sharing one mains inlet valve between N machine controllers;
// each grant keeps the valve open for FILL_COUNTS non-paused clocks, then pulses fill_done.
module water_supply_arbiter #(
    parameter int N_MACHINES  = 4,
    parameter int FILL_COUNTS = 10,
    parameter int CNT_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    water_supply_arbiter_if.slave bus
);
    localparam int PTR_W = (N_MACHINES > 1) ? $clog2(N_MACHINES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILL_COUNTS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_MACHINES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N_MACHINES-1:0] grant_q, grant_d;
    logic [N_MACHINES-1:0] fill_done_q, fill_done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [PTR_W-1:0]      sel_s;

    function automatic logic [N_MACHINES-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_MACHINES-1:0] v;
        v      = {N_MACHINES{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // First requester found scanning ptr, ptr+1, ... modulo N.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_MACHINES-1:0] r,
                                                 input logic [PTR_W-1:0]      ptr);
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_MACHINES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_MACHINES) begin
                idx = idx - N_MACHINES;
            end
            if (!found && r[idx[PTR_W-1:0]]) begin
                pick  = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Next-state and next-output computation for the valve FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        fill_done_d = {N_MACHINES{1'b0}};
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        sel_s       = rr_pick(bus.req, rr_ptr_q);
        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    owner_d = sel_s;
                    grant_d = onehot(sel_s);
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_FILL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                // Abandonment outranks pause so a withdrawn machine never keeps the valve.
                if (!bus.req[owner_q]) begin
                    grant_d  = {N_MACHINES{1'b0}};
                    rr_ptr_d = next_idx(owner_q);
                    state_d  = S_IDLE;
                end else if (bus.pause) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_LAST) begin
                    grant_d     = {N_MACHINES{1'b0}};
                    fill_done_d = onehot(owner_q);
                    rr_ptr_d    = next_idx(owner_q);
                    state_d     = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                grant_d = {N_MACHINES{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= {N_MACHINES{1'b0}};
            fill_done_q <= {N_MACHINES{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rr_ptr_q    <= {PTR_W{1'b0}};
            owner_q     <= {PTR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            fill_done_q <= fill_done_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.fill_done  = fill_done_q;
    assign bus.valve_open = (state_q == S_FILL) & ~bus.pause;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_water_supply_arbiter.sv
// Directed self-checking bench for water_supply_arbiter (N=4, FILL_COUNTS=10).
module tb_water_supply_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    water_supply_arbiter_if #(.N_MACHINES(4)) bus_if ();

    water_supply_arbiter #(
        .N_MACHINES (4),
        .FILL_COUNTS(10),
        .CNT_W      (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus_if.req    = 4'b0000;
        bus_if.pause  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus_if.pause = 1'b0;
        bus_if.req   = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus_if.grant, bus_if.fill_done, bus_if.valve_open, bus_if.busy} !== 10'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: grant=%b fill_done=%b valve=%b busy=%b, required all zero",
                         i, bus_if.grant, bus_if.fill_done, bus_if.valve_open, bus_if.busy);
            end
        end
        bus_if.req = 4'b0000;
        rst_n      = 1'b1;
        step();
    endtask

    task automatic test_single_fill();
        int opens;
        do_reset();
        opens      = 0;
        bus_if.req = 4'b0100;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (bus_if.valve_open === 1'b1) opens++;
            checks++;
            if (bus_if.grant !== 4'b0100 || bus_if.fill_done !== 4'b0000 || bus_if.busy !== 1'b1) begin
                errors++;
                $display("FAIL single_hold e%0d: grant=%b fill_done=%b busy=%b, required 0100/0000/1",
                         e, bus_if.grant, bus_if.fill_done, bus_if.busy);
            end
        end
        step();
        checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.fill_done !== 4'b0100 || bus_if.valve_open !== 1'b0) begin
            errors++;
            $display("FAIL single_done: grant=%b fill_done=%b valve=%b, required 0000/0100/0",
                     bus_if.grant, bus_if.fill_done, bus_if.valve_open);
        end
        bus_if.req = 4'b0000;
        step();
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.fill_done !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle: busy=%b fill_done=%b, required 0/0000", bus_if.busy, bus_if.fill_done);
        end
        checks++;
        if (opens !== 10) begin
            errors++;
            $display("FAIL single_open_cycles: got %0d, required 10", opens);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        bus_if.req = 4'b1111;
        step();
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            checks++;
            if (bus_if.grant !== exp_g) begin
                errors++;
                $display("FAIL rr_grant%0d: grant=%b, required %b", k, bus_if.grant, exp_g);
            end
            for (int e = 0; e < 9; e++) step();
            checks++;
            if (bus_if.grant !== exp_g) begin
                errors++;
                $display("FAIL rr_hold%0d: grant=%b, required %b", k, bus_if.grant, exp_g);
            end
            step();
            checks++;
            if (bus_if.fill_done !== exp_g || bus_if.grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_done%0d: fill_done=%b grant=%b, required %b/0000",
                         k, bus_if.fill_done, bus_if.grant, exp_g);
            end
            bus_if.req = bus_if.req & ~exp_g;
            step();
            checks++;
            if (bus_if.grant !== 4'b0000 || bus_if.valve_open !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap%0d: grant=%b valve=%b, required 0000/0", k, bus_if.grant, bus_if.valve_open);
            end
            step();
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_end_idle: busy=%b, required 0", bus_if.busy);
        end
    endtask

    task automatic test_pause();
        int opens;
        do_reset();
        opens      = 0;
        bus_if.req = 4'b0010;
        for (int e = 1; e <= 13; e++) begin
            step();
            if (bus_if.valve_open === 1'b1) opens++;
            checks++;
            if (bus_if.grant !== 4'b0010 || bus_if.fill_done !== 4'b0000) begin
                errors++;
                $display("FAIL pause_hold e%0d: grant=%b fill_done=%b, required 0010/0000",
                         e, bus_if.grant, bus_if.fill_done);
            end
            if (e == 6) begin
                bus_if.pause = 1'b1;
                #1;
                checks++;
                if (bus_if.valve_open !== 1'b0) begin
                    errors++;
                    $display("FAIL pause_valve: valve=%b, required 0", bus_if.valve_open);
                end
            end
            if (e == 9) bus_if.pause = 1'b0;
        end
        step();
        checks++;
        if (bus_if.fill_done !== 4'b0010 || bus_if.grant !== 4'b0000) begin
            errors++;
            $display("FAIL pause_done: fill_done=%b grant=%b, required 0010/0000", bus_if.fill_done, bus_if.grant);
        end
        checks++;
        if (opens !== 10) begin
            errors++;
            $display("FAIL pause_open_cycles: got %0d, required 10", opens);
        end
        bus_if.req = 4'b0000;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        bus_if.req = 4'b1000;
        for (int e = 1; e <= 5; e++) step();
        checks++;
        if (bus_if.grant !== 4'b1000) begin
            errors++;
            $display("FAIL abort_owner: grant=%b, required 1000", bus_if.grant);
        end
        bus_if.req = 4'b0001;
        step();
        checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.fill_done !== 4'b0000 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: grant=%b fill_done=%b busy=%b, required 0000/0000/0",
                     bus_if.grant, bus_if.fill_done, bus_if.busy);
        end
        step();
        checks++;
        if (bus_if.grant !== 4'b0001 || bus_if.fill_done !== 4'b0000) begin
            errors++;
            $display("FAIL abort_regrant: grant=%b fill_done=%b, required 0001/0000", bus_if.grant, bus_if.fill_done);
        end
        bus_if.req = 4'b0000;
        step();
    endtask

    task automatic test_reset_midfill();
        int opens;
        do_reset();
        bus_if.req = 4'b0100;
        for (int e = 1; e <= 8; e++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.grant !== 4'b0000 || bus_if.valve_open !== 1'b0 || bus_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL midfill_async: grant=%b valve=%b busy=%b, required 0000/0/0",
                     bus_if.grant, bus_if.valve_open, bus_if.busy);
        end
        bus_if.req = 4'b0010;
        step();
        rst_n = 1'b1;
        opens = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (bus_if.valve_open === 1'b1) opens++;
            checks++;
            if (bus_if.grant !== 4'b0010) begin
                errors++;
                $display("FAIL midfill_regrant e%0d: grant=%b, required 0010", e, bus_if.grant);
            end
        end
        step();
        checks++;
        if (bus_if.fill_done !== 4'b0010 || opens !== 10) begin
            errors++;
            $display("FAIL midfill_done: fill_done=%b opens=%0d, required 0010/10", bus_if.fill_done, opens);
        end
        bus_if.req = 4'b0000;
        step();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus_if.req   = 4'b0000;
        bus_if.pause = 1'b0;
        test_reset();
        test_single_fill();
        test_round_robin();
        test_pause();
        test_abort();
        test_reset_midfill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
